// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared sizing and types for the ALU issue scheduler.
//   NCOMMIT_DEF  - default number of commit slots (power of two)
//   LNCOMMIT_DEF - log2(NCOMMIT_DEF)
//   NALU_DEF     - default number of ALU issue ports
//   commit_idx_t / commit_mask_t - slot index and per-slot mask at default size
package alu_sched_pkg;
  localparam int NCOMMIT_DEF  = 32;
  localparam int LNCOMMIT_DEF = 5;
  localparam int NALU_DEF     = 2;

  typedef logic [LNCOMMIT_DEF-1:0] commit_idx_t;
  typedef logic [NCOMMIT_DEF-1:0]  commit_mask_t;
endpackage

// File: rtl/alu_issue_sel_if.sv
// alu_issue_sel_if: issue-selector bus between commit bookkeeping and the selector.
//   master (bookkeeping side): drives start_commit, ready, retire, kill, alu_busy;
//                              receives alu_enable, alu_addr, issued.
//   slave  (selector side)   : the reverse.
interface alu_issue_sel_if #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NALU     = 2
) ();
  logic [LNCOMMIT-1:0]      start_commit;
  logic [NCOMMIT-1:0]       ready;
  logic [NCOMMIT-1:0]       retire;
  logic [NCOMMIT-1:0]       kill;
  logic [NALU-1:0]          alu_busy;
  logic [NALU-1:0]          alu_enable;
  logic [NALU*LNCOMMIT-1:0] alu_addr;
  logic [NCOMMIT-1:0]       issued;

  modport master (
    output start_commit, ready, retire, kill, alu_busy,
    input  alu_enable, alu_addr, issued
  );

  modport slave (
    input  start_commit, ready, retire, kill, alu_busy,
    output alu_enable, alu_addr, issued
  );
endinterface

// File: rtl/commit_rot.sv
// commit_rot: combinational N-bit barrel rotator.
//   data_i - input vector
//   amt_i  - rotate amount (0..N-1)
//   dir_i  - 0: rotate right (bit amt moves to bit 0), 1: rotate left
//   data_o - rotated vector
module commit_rot #(
  parameter int N  = 32,
  parameter int LN = 5
) (
  input  logic [N-1:0]  data_i,
  input  logic [LN-1:0] amt_i,
  input  logic          dir_i,
  output logic [N-1:0]  data_o
);
  // st[k] is the vector after applying amount bits 0..k-1
  logic [LN:0][N-1:0] st;

  assign st[0] = data_i;

  genvar gi, gj;
  generate
    for (gi = 0; gi < LN; gi++) begin : g_stage
      for (gj = 0; gj < N; gj++) begin : g_bit
        localparam int SRC_R = (gj + (1 << gi)) % N;
        localparam int SRC_L = (gj + N - (1 << gi)) % N;
        assign st[gi+1][gj] = amt_i[gi] ? (dir_i ? st[gi][SRC_L] : st[gi][SRC_R])
                                        : st[gi][gj];
      end
    end
  endgenerate

  assign data_o = st[LN];
endmodule

// File: rtl/alu_issue_sel.sv
// alu_issue_sel: per-cycle issue selector for the integer ALU cluster.
// Grants the oldest ready, not-yet-issued commit slots to up to NALU ports and
// tracks in-flight slots until retire/kill.
//   clk, reset      - clock, synchronous active-high reset
//   bus (slave)     - start_commit, ready, retire, kill, alu_busy in;
//                     alu_enable, alu_addr, issued out (all registered)
//   perf_issue_cnt  - saturating grant count      (ALU_ISSUE_SEL_PERF_EN only)
//   perf_starve_cnt - saturating starved cycles   (ALU_ISSUE_SEL_PERF_EN only)
module alu_issue_sel
  import alu_sched_pkg::*;
#(
  parameter int NCOMMIT  = NCOMMIT_DEF,
  parameter int LNCOMMIT = LNCOMMIT_DEF,
  parameter int NALU     = NALU_DEF
) (
  input  logic        clk,
  input  logic        reset,
`ifdef ALU_ISSUE_SEL_PERF_EN
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_starve_cnt,
`endif
  alu_issue_sel_if.slave bus
);
  logic [NCOMMIT-1:0]             cand;
  logic [NCOMMIT-1:0]             cand_rot;
  logic [NCOMMIT-1:0]             gmask_rot;
  logic [NCOMMIT-1:0]             gmask;
  logic [NALU-1:0]                en_d, en_q;
  logic [NALU-1:0][LNCOMMIT-1:0]  addr_d, addr_q;
  logic [NCOMMIT-1:0]             issued_d, issued_q;

  // Lowest set bit = oldest candidate once the mask is age-rotated
  function automatic logic [LNCOMMIT-1:0] find_first(input logic [NCOMMIT-1:0] m);
    find_first = '0;
    for (int i = NCOMMIT - 1; i >= 0; i--) begin
      if (m[i]) find_first = i[LNCOMMIT-1:0];
    end
  endfunction

  assign cand = bus.ready & ~issued_q & ~bus.kill;

  commit_rot #(.N(NCOMMIT), .LN(LNCOMMIT)) u_rot_in (
    .data_i (cand),
    .amt_i  (bus.start_commit),
    .dir_i  (1'b0),
    .data_o (cand_rot)
  );

  // Busy ports are skipped without consuming a candidate, so the next free
  // port still receives the oldest remaining op.
  always_comb begin
    logic [NCOMMIT-1:0]  rem;
    logic [LNCOMMIT-1:0] pos;
    rem       = cand_rot;
    pos       = '0;
    en_d      = '0;
    addr_d    = addr_q;
    gmask_rot = '0;
    for (int p = 0; p < NALU; p++) begin
      if (!bus.alu_busy[p] && (rem != '0)) begin
        pos            = find_first(rem);
        en_d[p]        = 1'b1;
        addr_d[p]      = pos + bus.start_commit;  // wraps by truncation
        gmask_rot[pos] = 1'b1;
        rem[pos]       = 1'b0;
      end
    end
  end

  // Bring the granted positions back into slot numbering for the issued mask
  commit_rot #(.N(NCOMMIT), .LN(LNCOMMIT)) u_rot_out (
    .data_i (gmask_rot),
    .amt_i  (bus.start_commit),
    .dir_i  (1'b1),
    .data_o (gmask)
  );

  // Retire/kill clear dominates a fresh grant on the same slot
  assign issued_d = (issued_q | gmask) & ~(bus.retire | bus.kill);

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= '0;
      addr_q   <= '0;
      issued_q <= '0;
    end else begin
      en_q     <= en_d;
      addr_q   <= addr_d;
      issued_q <= issued_d;
    end
  end

  assign bus.alu_enable = en_q;
  assign bus.alu_addr   = addr_q;
  assign bus.issued     = issued_q;

`ifdef ALU_ISSUE_SEL_PERF_EN
  logic        starve_q;
  logic [31:0] issue_inc;
  logic [31:0] issue_cnt_q, starve_cnt_q;

  assign issue_inc = 32'($countones(en_q));

  // Counters advance on the registered grant/starve events
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= 1'b0;
      issue_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      starve_q <= (cand != '0) && (&bus.alu_busy);
      if (issue_cnt_q > (32'hFFFF_FFFF - issue_inc)) issue_cnt_q <= 32'hFFFF_FFFF;
      else                                           issue_cnt_q <= issue_cnt_q + issue_inc;
      if (starve_q && (starve_cnt_q != 32'hFFFF_FFFF)) starve_cnt_q <= starve_cnt_q + 32'd1;
    end
  end

  assign perf_issue_cnt  = issue_cnt_q;
  assign perf_starve_cnt = starve_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_sel.sv
// tb_alu_issue_sel: directed-vector bench for alu_issue_sel (32 slots, 2 ports).
module tb_alu_issue_sel;
  import alu_sched_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

`ifdef ALU_ISSUE_SEL_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_starve_cnt;
`endif

  alu_issue_sel_if #(.NCOMMIT(32), .LNCOMMIT(5), .NALU(2)) bus ();

  alu_issue_sel #(.NCOMMIT(32), .LNCOMMIT(5), .NALU(2)) dut (
    .clk             (clk),
    .reset           (reset),
`ifdef ALU_ISSUE_SEL_PERF_EN
    .perf_issue_cnt  (perf_issue_cnt),
    .perf_starve_cnt (perf_starve_cnt),
`endif
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addr0();
    return {27'd0, bus.alu_addr[4:0]};
  endfunction

  function automatic logic [31:0] addr1();
    return {27'd0, bus.alu_addr[9:5]};
  endfunction

  initial begin
    commit_mask_t m;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    bus.start_commit = '0;
    bus.ready        = '0;
    bus.retire       = '0;
    bus.kill         = '0;
    bus.alu_busy     = '0;
    step();
    step();
    check_eq("rst_issued", bus.issued, 32'h0);
    check_eq("rst_en", {30'd0, bus.alu_enable}, 32'h0);
    check_eq("rst_addr", {22'd0, bus.alu_addr}, 32'h0);

    // Reset mid-operation
    reset = 1'b0;
    bus.ready = 32'h0000_00F0;
    step();
    check_eq("mid_en_a", {30'd0, bus.alu_enable}, 32'h3);
    check_eq("mid_issued_a", bus.issued, 32'h0000_0030);
    step();
    check_eq("mid_addr0", addr0(), 32'd6);
    check_eq("mid_addr1", addr1(), 32'd7);
    check_eq("mid_issued_b", bus.issued, 32'h0000_00F0);
    reset = 1'b1;
    step();
    check_eq("mid_rst_issued", bus.issued, 32'h0);
    check_eq("mid_rst_en", {30'd0, bus.alu_enable}, 32'h0);
    check_eq("mid_rst_addr", {22'd0, bus.alu_addr}, 32'h0);
    reset = 1'b0;
    bus.ready = '0;
    step();
    check_eq("empty_en", {30'd0, bus.alu_enable}, 32'h0);

    // Age order with wrap-around
    bus.start_commit = 5'd30;
    m = '0; m[31] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
    bus.ready = m;
    step();
    check_eq("wrap_en_a", {30'd0, bus.alu_enable}, 32'h3);
    check_eq("wrap_addr0_a", addr0(), 32'd31);
    check_eq("wrap_addr1_a", addr1(), 32'd1);
    step();
    check_eq("wrap_en_b", {30'd0, bus.alu_enable}, 32'h1);
    check_eq("wrap_addr0_b", addr0(), 32'd2);
    check_eq("wrap_addr1_hold", addr1(), 32'd1);
    check_eq("wrap_issued", bus.issued, 32'h8000_0006);
    bus.ready = '0;
    bus.retire = m;
    step();
    check_eq("wrap_retire", bus.issued, 32'h0);
    bus.retire = '0;
    bus.start_commit = '0;

    // Busy port skipped without consuming a candidate
    bus.ready = 32'h0000_0060;
    bus.alu_busy = 2'b01;
    step();
    check_eq("busy_en", {30'd0, bus.alu_enable}, 32'h2);
    check_eq("busy_addr1", addr1(), 32'd5);
    check_eq("busy_issued", bus.issued, 32'h0000_0020);
    bus.ready = '0;
    bus.alu_busy = '0;
    bus.retire = 32'h0000_0020;
    step();
    bus.retire = '0;

    // No double issue while held ready; re-issue after retire
    bus.ready = 32'h0000_0080;
    step();
    check_eq("hold_en_1", {30'd0, bus.alu_enable}, 32'h1);
    check_eq("hold_addr_1", addr0(), 32'd7);
    step();
    check_eq("hold_en_2", {30'd0, bus.alu_enable}, 32'h0);
    step();
    check_eq("hold_en_3", {30'd0, bus.alu_enable}, 32'h0);
    bus.retire = 32'h0000_0080;
    step();
    check_eq("retire_en", {30'd0, bus.alu_enable}, 32'h0);
    check_eq("retire_issued", bus.issued, 32'h0);
    bus.retire = '0;
    step();
    check_eq("reissue_en", {30'd0, bus.alu_enable}, 32'h1);
    check_eq("reissue_addr", addr0(), 32'd7);
    bus.ready = '0;
    bus.retire = 32'h0000_0080;
    step();
    bus.retire = '0;

    // Kill blocks grant and clears issued
    bus.ready = 32'h0000_0200;
    bus.kill  = 32'h0000_0200;
    step();
    check_eq("kill_en", {30'd0, bus.alu_enable}, 32'h0);
    check_eq("kill_issued", bus.issued, 32'h0);
    bus.kill = '0;
    step();
    check_eq("post_kill_en", {30'd0, bus.alu_enable}, 32'h1);
    check_eq("post_kill_addr", addr0(), 32'd9);
    check_eq("post_kill_issued", bus.issued, 32'h0000_0200);
    bus.ready = '0;
    bus.kill  = 32'h0000_0200;
    step();
    check_eq("kill_clear", bus.issued, 32'h0);
    bus.kill = '0;

    // All ports busy: nothing granted
    bus.ready = 32'h0000_0003;
    bus.alu_busy = 2'b11;
    step();
    check_eq("allbusy_en", {30'd0, bus.alu_enable}, 32'h0);
    check_eq("allbusy_issued", bus.issued, 32'h0);

`ifdef ALU_ISSUE_SEL_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.ready = 32'h0000_0003;
    bus.alu_busy = 2'b11;
    for (int i = 0; i < 4; i++) step();
    bus.alu_busy = 2'b00;
    step();
    bus.ready = '0;
    for (int i = 0; i < 3; i++) step();
    check_eq("perf_starve", perf_starve_cnt, 32'd4);
    check_eq("perf_issue", perf_issue_cnt, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/alu_issue_sel.md
Name: alu_issue_sel

Overview:
- Per-cycle issue selector for the integer ALU cluster.
- Takes a ready mask over the NCOMMIT commit slots and the commit-head pointer, then grants the oldest ready, not-yet-issued slots to up to NALU ALU ports.
- Tracks in-flight (issued) slots until they retire or are killed.
- Sits between rename/commit bookkeeping and the ALU datapaths.

Parameters:
- NCOMMIT, 32, number of commit slots; power of two.
- LNCOMMIT, 5, log2(NCOMMIT).
- NALU, 2, number of ALU issue ports; 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_commit  in  LNCOMMIT  commit-head slot index (oldest instruction)
- ready  in  NCOMMIT  slot operands ready and slot is an ALU op
- retire  in  NCOMMIT  slot committed this cycle; clears issued bit
- kill  in  NCOMMIT  slot flushed this cycle; clears issued bit, blocks grant
- alu_busy  in  NALU  port i cannot accept an op this cycle
- alu_enable  out  NALU  port i issues this cycle
- alu_addr  out  NALU*LNCOMMIT  slot index for port i, packed, port 0 in LSBs
- issued  out  NCOMMIT  in-flight mask (registered)

Behaviour:
- Clock is clk. Reset is synchronous, active-high, named reset.
- Reset: alu_enable=0, alu_addr=0, issued=0. Reset wins over every other input on the same edge.
- Candidate mask: cand = ready & ~issued & ~kill.
- Age order: rotate cand right by start_commit so bit 0 is the oldest slot. Rotation uses a barrel-rotate sub-module.
- Grant order: ports 0..NALU-1 in order.
  - Each port with alu_busy=0 takes the lowest set bit remaining in the rotated mask; that bit is then removed.
  - A busy port takes nothing and consumes no candidate, so the next free port receives the older op.
- Chosen slot index is (rotated position + start_commit) mod NCOMMIT; wrap-around is natural LNCOMMIT-bit truncation.
- Outputs are registered, 1-cycle latency: inputs sampled at edge N appear on alu_enable/alu_addr after edge N.
- alu_addr for a port with alu_enable=0 holds its previous value; it is don't-care to consumers but deterministic.
- Issued bit per slot s, next-state priority high to low:
  1. reset -> 0
  2. retire[s] | kill[s] -> 0
  3. granted at this edge -> 1
  4. otherwise hold
- Kill and ready on the same slot in the same cycle: no grant, issued cleared.
- Fewer candidates than free ports: remaining ports get alu_enable=0.
- All ports busy: no grants, issued unchanged except retire/kill clears.
- ready is asserted for an already-issued slot: no grant (no double issue).
- Empty ready mask: all enables 0.

Optional Feature:
- Macro ALU_ISSUE_SEL_PERF_EN.
- When defined, adds outputs:
  - perf_issue_cnt, 32 bits: total grants, saturating.
  - perf_starve_cnt, 32 bits: cycles where cand is nonzero and every port is busy, saturating.
- Both counters reset to 0 and increment on registered events.
- When undefined, the ports and logic are absent; grant behaviour is identical.

Decomposition:
- Shared package alu_sched_pkg holds:
  - NCOMMIT_DEF / LNCOMMIT_DEF localparams
  - typedef commit_idx_t (logic [LNCOMMIT-1:0])
  - typedef commit_mask_t (logic [NCOMMIT-1:0])
- One sub-module, commit_rot: a parameterised NCOMMIT barrel rotator with a direction input. It is used twice: mask rotate in, index unrotate out.
- The priority find-first stays inline as a function.

Test Plan:
- Reset mid-operation: issued=0xF0 and enables active, assert reset for 1 cycle -> next cycle issued=0, alu_enable=0, alu_addr=0.
- Age and wrap-around:
  - start_commit=30, ready=bits{31,1,2}, no busy -> next cycle port0 addr=31, port1 addr=1.
  - Following cycle, ready held, port0 addr=2, port1 disabled.
- Busy skip: ready=bits{5,6}, start_commit=0, alu_busy=2'b01 -> port1 enable, addr=5; port0 disabled; issued[5]=1, issued[6]=0.
- No double issue:
  - Hold ready[7]=1 for 3 cycles -> exactly one grant of 7.
  - Pulse retire[7] and keep ready -> slot 7 granted again one cycle later.
- Kill priority: ready[9]=1 and kill[9]=1 in the same cycle -> no grant. Slot 9 already issued plus kill[9] -> issued[9]=0 next cycle.
- Perf (ALU_ISSUE_SEL_PERF_EN): 4 cycles alu_busy=2'b11 with ready nonzero, then 1 cycle free with 2 candidates -> perf_starve_cnt=4, perf_issue_cnt=2.
